// File: rtl/board_init_if.sv
// Control and write-port bundle between the board initialiser and its
// environment.
interface board_init_if #(
  parameter int ADDR_W = 8,
  parameter int CELL_W = 2
);
  logic              start;
  logic [1:0]        mode;
  logic              hold;
  logic              busy;
  logic              done;
  logic              wren;
  logic [ADDR_W-1:0] addr;
  logic [CELL_W-1:0] data;

  modport master (input start, mode, hold, output busy, done, wren, addr, data);
  modport slave  (output start, mode, hold, input busy, done, wren, addr, data);
endinterface

// File: rtl/board_init.sv
// Board memory initialiser: streams one fill pattern over a SIDE x SIDE board,
// one cell per unstalled cycle in ascending address order.
module board_init #(
  parameter int SIDE      = 10,
  parameter int CELL_W    = 2,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input logic          i_clock,
  input logic          i_reset,
  board_init_if.master io_bus
);
  // state | meaning
  // IDLE  | after reset, waiting for start
  // WRITE | issuing one cell write per cycle without hold
  // DONE  | pass complete, done held until the next start
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  localparam int RC_W = $clog2(SIDE);
  localparam logic [RC_W-1:0]   LAST  = RC_W'(SIDE - 1);
  localparam logic [RC_W-1:0]   C0    = RC_W'(SIDE / 2 - 1);
  localparam logic [RC_W-1:0]   C1    = RC_W'(SIDE / 2);
  localparam logic [CELL_W-1:0] EMPTY = CELL_W'(0);
  localparam logic [CELL_W-1:0] BLACK = CELL_W'(1);
  localparam logic [CELL_W-1:0] WHITE = CELL_W'(2);
  localparam logic [CELL_W-1:0] WALL  = CELL_W'(3);

  state_t            r_state, w_state_n;
  logic [RC_W-1:0]   r_row, r_col, w_row_n, w_col_n;
  logic [1:0]        r_mode, w_mode_n;
  logic              r_busy, r_done, r_wren, w_busy_n, w_done_n, w_wren_n;
  logic [ADDR_W-1:0] r_addr, w_addr_n, w_cell_addr;
  logic [CELL_W-1:0] r_data, w_data_n, w_pattern;
  logic              w_last, w_wall, w_diag, w_anti;

  assign w_last = (r_row == LAST) && (r_col == LAST);
  assign w_wall = (r_row == '0) || (r_row == LAST) || (r_col == '0) || (r_col == LAST);
  assign w_diag = ((r_row == C0) && (r_col == C0)) || ((r_row == C1) && (r_col == C1));
  assign w_anti = ((r_row == C0) && (r_col == C1)) || ((r_row == C1) && (r_col == C0));
  assign w_cell_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(r_row) * ADDR_W'(SIDE) + ADDR_W'(r_col);

  // Mode 3 falls through to the plain clear pattern.
  always_comb begin
    w_pattern = EMPTY;
    if (w_wall) begin
      w_pattern = WALL;
    end else if (r_mode == 2'd1) begin
      if (w_diag)      w_pattern = WHITE;
      else if (w_anti) w_pattern = BLACK;
    end else if (r_mode == 2'd2) begin
      if (w_diag)      w_pattern = BLACK;
      else if (w_anti) w_pattern = WHITE;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_mode  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wren  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_n;
      r_row   <= w_row_n;
      r_col   <= w_col_n;
      r_mode  <= w_mode_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_wren  <= w_wren_n;
      r_addr  <= w_addr_n;
      r_data  <= w_data_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (io_bus.start) w_state_n = S_WRITE;
      S_WRITE:        if (!io_bus.hold && w_last) w_state_n = S_DONE;
      default:        w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_row_n  = r_row;
    w_col_n  = r_col;
    w_mode_n = r_mode;
    w_busy_n = r_busy;
    w_done_n = r_done;
    w_wren_n = 1'b0;
    w_addr_n = r_addr;
    w_data_n = r_data;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_state == S_DONE) begin
          w_busy_n = 1'b0;
          w_done_n = 1'b1;
        end
        if (io_bus.start) begin
          w_mode_n = io_bus.mode;
          w_row_n  = '0;
          w_col_n  = '0;
          w_busy_n = 1'b1;
          w_done_n = 1'b0;
        end
      end
      S_WRITE: begin
        if (!io_bus.hold) begin
          w_wren_n = 1'b1;
          w_addr_n = w_cell_addr;
          w_data_n = w_pattern;
          if (r_col == LAST) begin
            w_col_n = '0;
            w_row_n = r_row + 1'b1;
          end else begin
            w_col_n = r_col + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign io_bus.busy = r_busy;
  assign io_bus.done = r_done;
  assign io_bus.wren = r_wren;
  assign io_bus.addr = r_addr;
  assign io_bus.data = r_data;
endmodule

// File: tb/tb_board_init.sv
// Randomised scoreboard bench for board_init: expected writes are queued per
// pass from a cell-index reference model and popped by write monitors.
module tb_board_init;
  localparam int SIDE = 10;
  localparam int N    = SIDE * SIDE;
  localparam int S6   = 6;
  localparam int B6   = 16;

  typedef struct packed {
    logic [7:0] a;
    logic [1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  wr_t  exp_q[$];
  wr_t  exp6_q[$];
  wr_t  e0, e6;

  board_init_if #(.ADDR_W(8), .CELL_W(2)) bus  ();
  board_init_if #(.ADDR_W(8), .CELL_W(2)) bus6 ();

  board_init #(.SIDE(SIDE), .CELL_W(2), .ADDR_W(8), .BASE_ADDR(0)) dut (
    .i_clock(clk), .i_reset(rst), .io_bus(bus));
  board_init #(.SIDE(S6), .CELL_W(2), .ADDR_W(8), .BASE_ADDR(B6)) dut6 (
    .i_clock(clk), .i_reset(rst), .io_bus(bus6));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference cell value from a linear cell index.
  function automatic logic [1:0] ref_cell(input int side, input int m, input int idx);
    int r, c, lo, hi;
    r  = idx / side;
    c  = idx % side;
    lo = side / 2 - 1;
    hi = side / 2;
    if (r == 0 || c == 0 || r == side - 1 || c == side - 1) return 2'd3;
    if (m == 1 || m == 2) begin
      if ((r == lo && c == lo) || (r == hi && c == hi)) return (m == 1) ? 2'd2 : 2'd1;
      if ((r == lo && c == hi) || (r == hi && c == lo)) return (m == 1) ? 2'd1 : 2'd2;
    end
    return 2'd0;
  endfunction

  always @(negedge clk) begin
    if (bus.wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_write: got addr %0d, expected no write", bus.addr);
      end else begin
        e0 = exp_q.pop_front();
        check("wr_addr", 32'(bus.addr), 32'(e0.a));
        check("wr_data", 32'(bus.data), 32'(e0.d));
      end
    end
  end

  always @(negedge clk) begin
    if (bus6.wren === 1'b1) begin
      if (exp6_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_write6: got addr %0d, expected no write", bus6.addr);
      end else begin
        e6 = exp6_q.pop_front();
        check("wr6_addr", 32'(bus6.addr), 32'(e6.a));
        check("wr6_data", 32'(bus6.data), 32'(e6.d));
      end
    end
  end

  // hmode: 0 no hold, 1 random hold, 2 three-cycle hold before address 37.
  task automatic run_pass(input int m, input int hmode, input bit repulse);
    int t, stalls, held, issued, budget;
    logic hv;
    for (int i = 0; i < N; i++) exp_q.push_back('{a: 8'(i), d: ref_cell(SIDE, m, i)});
    stalls = 0; held = 0; issued = 0; budget = 0;
    bus.start = 1'b1;
    bus.mode  = 2'(m);
    bus.hold  = 1'b0;
    @(posedge clk); #1;
    t = cyc;
    bus.start = 1'b0;
    check("accept_busy", 32'(bus.busy), 32'd1);
    check("accept_done", 32'(bus.done), 32'd0);
    while (bus.done !== 1'b1 && budget < 3000) begin
      hv = 1'b0;
      if (hmode == 1) hv = ($urandom_range(0, 3) == 0);
      else if (hmode == 2 && issued == 37 && held < 3) begin
        hv = 1'b1;
        held++;
      end
      if (hv && issued < N) stalls++;
      bus.hold = hv;
      if (repulse && issued == 20) begin
        bus.start = 1'b1;
        bus.mode  = 2'(m ^ 3);
      end else begin
        bus.start = 1'b0;
        bus.mode  = 2'(m);
      end
      @(posedge clk); #1;
      budget++;
      if (bus.wren === 1'b1) issued++;
    end
    bus.hold  = 1'b0;
    bus.start = 1'b0;
    check("done_seen", 32'(bus.done), 32'd1);
    check("done_cycle", 32'(cyc - t), 32'(N + 1 + stalls));
    check("done_busy", 32'(bus.busy), 32'd0);
    check("done_wren", 32'(bus.wren), 32'd0);
    check("done_addr_hold", 32'(bus.addr), 32'(N - 1));
    check("writes_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int issued, budget, t;
    rst = 1'b1;
    bus.start = 1'b0;  bus.mode = 2'd0;  bus.hold = 1'b0;
    bus6.start = 1'b0; bus6.mode = 2'd0; bus6.hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_wren", 32'(bus.wren), 32'd0);
    check("rst_addr", 32'(bus.addr), 32'd0);
    check("rst_data", 32'(bus.data), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_pass(0, 0, 0);
    run_pass(1, 0, 0);
    run_pass(2, 0, 0);
    run_pass(1, 2, 0);
    run_pass(1, 0, 1);
    run_pass(3, 1, 0);
    for (int k = 0; k < 4; k++) run_pass(int'($urandom_range(0, 3)), 1, 1'($urandom_range(0, 1)));

    // Abort a mode-1 pass with reset just as address 50 would be written.
    for (int i = 0; i < N; i++) exp_q.push_back('{a: 8'(i), d: ref_cell(SIDE, 1, i)});
    bus.start = 1'b1;
    bus.mode  = 2'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    issued = 0; budget = 0;
    while (issued < 50 && budget < 500) begin
      @(posedge clk); #1;
      budget++;
      if (bus.wren === 1'b1) issued++;
    end
    check("abort_reached", 32'(issued), 32'd50);
    rst = 1'b1;
    bus.start = 1'b1;
    bus.mode  = 2'd0;
    @(posedge clk); #1;
    check("abort_wren", 32'(bus.wren), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_addr", 32'(bus.addr), 32'd0);
    check("abort_left", 32'(exp_q.size()), 32'(N - 50));
    exp_q.delete();
    @(posedge clk); #1;
    check("rst_start_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    run_pass(0, 0, 0);

    // Smaller board at a nonzero base address.
    for (int i = 0; i < S6 * S6; i++) exp6_q.push_back('{a: 8'(B6 + i), d: ref_cell(S6, 1, i)});
    bus6.start = 1'b1;
    bus6.mode  = 2'd1;
    @(posedge clk); #1;
    t = cyc;
    bus6.start = 1'b0;
    budget = 0;
    while (bus6.done !== 1'b1 && budget < 500) begin
      @(posedge clk); #1;
      budget++;
    end
    check("s6_done_cycle", 32'(cyc - t), 32'(S6 * S6 + 1));
    check("s6_last_addr", 32'(bus6.addr), 32'(B6 + S6 * S6 - 1));
    check("s6_writes_left", 32'(exp6_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/board_init.md
BOARD_INIT -- requirements
Module: board_init

Interface
REQ-001 Parameter SIDE, default 10: board side in cells including the one-cell wall border; even, >= 4.
REQ-002 Parameter CELL_W, default 2: cell code width; codes EMPTY=0, BLACK=1, WHITE=2, WALL=3.
REQ-003 Parameter ADDR_W, default 8: memory address width; must satisfy 2^ADDR_W >= BASE_ADDR + SIDE*SIDE.
REQ-004 Parameter BASE_ADDR, default 0: address of cell (row 0, col 0).
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  request to begin an initialisation pass; sampled each cycle.
REQ-008 mode  in  2  fill pattern, latched on start acceptance: 0 clear, 1 standard opening, 2 swapped opening, 3 treated as 0.
REQ-009 hold  in  1  memory-port stall; when high, no write is issued and progress freezes.
REQ-010 busy  out  1  high while a pass is in progress.
REQ-011 done  out  1  high from pass completion until the next accepted start or reset.
REQ-012 wren  out  1  write enable to board memory.
REQ-013 addr  out  ADDR_W  write address.
REQ-014 data  out  CELL_W  write data.

Function
REQ-015 All outputs SHALL be registered; states IDLE, WRITE, DONE.
REQ-016 IDLE or DONE with start=1: go to WRITE next cycle; latch mode; clear row/col counters; done<=0, busy<=1.
REQ-017 start while in WRITE SHALL be ignored; latched mode unchanged.
REQ-018 In WRITE with hold=0: wren=1, addr=BASE_ADDR+row*SIDE+col, data=pattern(row,col); col increments, wrapping to 0 with row increment at col=SIDE-1.
REQ-019 In WRITE with hold=1: wren=0 that cycle; row, col, addr, data frozen; no cell skipped or repeated.
REQ-020 Cells SHALL be written in ascending address order, exactly once each, SIDE*SIDE writes per pass.
REQ-021 pattern: row or col equal to 0 or SIDE-1 -> WALL; otherwise EMPTY, except as in REQ-022.
REQ-022 With c0=SIDE/2-1, c1=SIDE/2: mode 1 writes (c0,c0),(c1,c1)=WHITE and (c0,c1),(c1,c0)=BLACK; mode 2 swaps the two colours; modes 0 and 3 leave them EMPTY.
REQ-023 After the write of row=col=SIDE-1 is issued: next cycle state DONE, wren=0, busy=0, done=1.
REQ-024 With hold=0 throughout, start accepted at edge t gives first write at cycle t+1, last at t+SIDE*SIDE, done=1 from t+SIDE*SIDE+1.
REQ-025 wren SHALL be 0 in IDLE and DONE; addr and data hold their last values there.
REQ-026 Address arithmetic SHALL be computed at ADDR_W bits without truncation for legal parameters.

Reset
REQ-027 reset=1 at an edge: state IDLE, counters 0, busy=0, done=0, wren=0, addr=0, data=0, latched mode=0.
REQ-028 reset SHALL take priority over start and hold; reset mid-pass aborts with no further writes.
REQ-029 start held high through reset release SHALL be accepted on the first edge with reset=0.

Verification
REQ-030 Defaults, mode 0, one-cycle start, hold=0 -> 100 writes addr 0..99; 36 WALL cells (rows/cols 0,9), 64 EMPTY; done at start edge +101.
REQ-031 Mode 1 -> addr 44,55 WHITE; 45,54 BLACK; remaining interior EMPTY; border WALL. Mode 2 -> 44,55 BLACK; 45,54 WHITE.
REQ-032 Mode 1, hold high 3 cycles at addr 37 -> wren=0 for those 3 cycles, next write addr 37, done delayed by exactly 3 cycles.
REQ-033 start re-pulsed with mode 2 during a mode-1 pass -> ignored, pass completes mode 1; start in DONE -> done drops next cycle, new pass begins at addr 0.
REQ-034 reset at write of addr 50 -> next cycle wren=0, busy=0, done=0, addr=0; new start restarts at addr 0.
REQ-035 SIDE=6, BASE_ADDR=16, mode 1 -> addr 16..51; cells (2,2),(3,3) WHITE at 30,37; (2,3),(3,2) BLACK at 31,36.
